// File: rtl/approx_mul_pkg.sv
// approx_mul_pkg
// Shared definitions for the approximate sequential multiplier:
//   mul_state_t  - FSM state encoding (IDLE, BUSY, DONE)
//   MAX_W2       - widest product supported by col_mask (so WIDTH <= 32)
//   col_mask()   - keep-mask over the result columns; a bit is 1 where a
//                  partial-product bit survives approximate mode
package approx_mul_pkg;

  localparam int MAX_W2 = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Bits [width2-1:trunc] are kept and everything below trunc is dropped.
  // Bits at or above width2 are 0 so callers can slice the low 2N bits.
  function automatic logic [MAX_W2-1:0] col_mask(input int width2, input int trunc);
    logic [MAX_W2-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_W2; i++) begin
      if (i >= trunc && i < width2) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/approx_pp_row.sv
// approx_pp_row
// Combinational generator for one partial-product row of the shift-add
// multiplier.
//   a        in  WIDTH    multiplicand
//   b_bit    in  1        multiplier bit selecting this row
//   row_idx  in  IDX_W    row index, i.e. the left-shift amount
//   approx   in  1        1 = zero the lowest TRUNC_COLS columns of the row
//   row      out 2*WIDTH  zero-extended, shifted and masked row
module approx_pp_row
  import approx_mul_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int TRUNC_COLS = 2,
  parameter int IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0]   a,
  input  logic               b_bit,
  input  logic [IDX_W-1:0]   row_idx,
  input  logic               approx,
  output logic [2*WIDTH-1:0] row
);

  localparam logic [MAX_W2-1:0] KEEP_FULL = col_mask(2 * WIDTH, TRUNC_COLS);

  logic [2*WIDTH-1:0] shifted;

  assign shifted = b_bit ? ({{WIDTH{1'b0}}, a} << row_idx) : '0;

  // The mask is a constant, so each column becomes either a wire or an AND
  // with ~approx. No mask register or runtime mask logic is needed.
  generate
    for (genvar gi = 0; gi < 2 * WIDTH; gi++) begin : g_col
      if (KEEP_FULL[gi]) begin : g_keep
        assign row[gi] = shifted[gi];
      end else begin : g_drop
        assign row[gi] = shifted[gi] & ~approx;
      end
    end
  endgenerate

endmodule

// File: rtl/approx_seq_mul.sv
// approx_seq_mul
// Unsigned WIDTH x WIDTH shift-add multiplier. It processes one partial-product
// row per cycle. Approximate mode drops every partial-product bit in the lowest
// TRUNC_COLS result columns. Latency is WIDTH edges from acceptance.
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready      operand handshake; in_ready is high only in IDLE
//   in_a, in_b, in_approx  operands and mode, sampled on acceptance
//   out_valid/out_ready    result handshake; out_valid is high only in DONE
//   out_p, out_approx      product and mode, held stable while stalled
module approx_seq_mul
  import approx_mul_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int TRUNC_COLS = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_approx,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               out_approx
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(WIDTH - 1);

  mul_state_t         state_reg, state_next;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic               approx_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [2*WIDTH-1:0] row;
  logic               accept;

  assign accept = (state_reg == IDLE) && in_valid;

  approx_pp_row #(
    .WIDTH      (WIDTH),
    .TRUNC_COLS (TRUNC_COLS),
    .IDX_W      (CNT_W)
  ) u_row (
    .a       (a_reg),
    .b_bit   (b_reg[cnt_reg]),
    .row_idx (cnt_reg),
    .approx  (approx_reg),
    .row     (row)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (in_valid)             state_next = BUSY;
      BUSY:    if (cnt_reg == LAST_ROW)  state_next = DONE;
      DONE:    if (out_ready)            state_next = IDLE;
      default:                           state_next = IDLE;
    endcase
  end

  // Handshake outputs are decoded from state only, so neither depends
  // combinationally on in_valid or out_ready.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_reg)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand, accumulator and row-counter registers. The accumulator is left
  // untouched in DONE, which keeps out_p stable under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      approx_reg <= 1'b0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
    end else if (accept) begin
      a_reg      <= in_a;
      b_reg      <= in_b;
      approx_reg <= in_approx;
      acc_reg    <= '0;
      cnt_reg    <= '0;
    end else if (state_reg == BUSY) begin
      acc_reg <= acc_reg + row;
      if (cnt_reg != LAST_ROW) cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign out_p      = acc_reg;
  assign out_approx = approx_reg;

endmodule

// File: doc/approx_seq_mul.md
# approx_seq_mul

Parametrised, sequential successor to the fixed 2-bit approximate multipliers: an N×N unsigned shift-add multiplier with a per-transaction exact/approximate mode, where approximate mode drops all partial-product bits in the lowest `TRUNC_COLS` result columns. It is the approximate arithmetic datapath element for the accelerator's MAC lanes. Operands enter and results leave through valid/ready handshakes, and latency is fixed.

## Interface
- `WIDTH`, 4, operand width N (≥2); result is 2N bits
- `TRUNC_COLS`, 2, number of least-significant result columns whose partial-product bits are zeroed in approximate mode (0..2N-1; 0 makes approximate mode equal to exact)
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  operand transfer request
- `in_ready`  out  1  block can accept operands
- `in_a`  in  WIDTH  multiplicand, unsigned
- `in_b`  in  WIDTH  multiplier, unsigned
- `in_approx`  in  1  1 = approximate mode, 0 = exact; sampled with operands
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer takes result
- `out_p`  out  2·WIDTH  product
- `out_approx`  out  1  mode the result was computed in

## Operation
- FSM states are IDLE, BUSY and DONE. Reset enters IDLE.
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready`:
  - latch `in_a`, `in_b` and `in_approx`
  - clear the accumulator and the row counter
  - go to BUSY
- BUSY: one row per cycle. Row i = `in_b[i]` ? (`a` << i) : 0, zero-extended to 2N bits.
  - If the latched mode is approximate, bits [TRUNC_COLS-1:0] of the row are forced to 0 before accumulation.
  - Accumulate the row into the 2N-bit accumulator. The sum never overflows.
  - The counter runs 0..WIDTH-1. After row WIDTH-1, go to DONE.
- DONE:
  - `out_valid`=1, with `out_p` = accumulator and `out_approx` = latched mode.
  - On `out_ready`, go to IDLE.
  - `out_p` and `out_approx` stay stable while `out_valid`=1 and `out_ready`=0.
- `in_ready`=0 in BUSY and DONE. Operands presented then are ignored and not queued.
- Exact mode result equals a·b. The approximate result is at most the exact result. The error equals the weighted sum of the dropped bits in columns < TRUNC_COLS.
- Reset values: `in_ready`=1 (IDLE), `out_valid`=0, `out_p`=0, `out_approx`=0. The accumulator, operands and counter are also 0.
- Reset asserted mid-BUSY or mid-DONE discards the transaction immediately and asynchronously, with no output pulse.

## Timing
- Accepting edge E0 loads the operands. Edges E1..E_WIDTH accumulate rows 0..WIDTH-1. `out_valid` is high after E_WIDTH, so latency is WIDTH edges from acceptance.
- The edge with `out_valid`&&`out_ready` returns the FSM to IDLE. `in_ready` is high in the following cycle.
- Minimum initiation interval is WIDTH+2 cycles when `out_ready` is held at 1.
- No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`. All outputs are registered or decoded from state.

## Structure
- Package `approx_mul_pkg` holds:
  - state enum `mul_state_t` {IDLE, BUSY, DONE}
  - function `col_mask(width2, trunc)` returning the 2N-bit keep-mask
- Sub-module `approx_pp_row` is combinational. It takes `a`, one bit of `b`, the row index, the mode, and `TRUNC_COLS`, and produces one masked 2N-bit row.
- The top level holds the FSM, the counter, the operand and accumulator registers, and the handshake logic.

## Test plan
- WIDTH=4, TRUNC_COLS=2, exact mode, a=3, b=3 → `out_p`=9 and `out_approx`=0, with `out_valid` high exactly 4 edges after acceptance.
- Same parameters, approximate mode, a=3, b=3 → `out_p`=4. Approximate mode, a=15, b=15 → `out_p`=220 (exact result is 225).
- Hold `out_ready`=0 for 5 cycles in DONE while driving new `in_valid` operands → result stable, `in_ready`=0, new operands ignored. Release → IDLE, and the next operands are accepted one cycle later.
- Deassert `rst_n` two cycles after acceptance → `out_valid`=0, `out_p`=0 and `in_ready`=1 immediately. After release, a fresh exact a=7, b=5 → 35.
- Randomised 1000 operand pairs with WIDTH=8, TRUNC_COLS=4, both modes, and random `out_ready` back-pressure. Compare against a reference model; in approximate mode also check 0 ≤ exact − approx ≤ the sum of the weights of the dropped bits.
